// File: rtl/seq_mult_param.sv
// Shift-add sequential multiplier, W x W -> 2W, one multiplier bit per clock.
// Signed or unsigned per operation, chosen with start. The product is held
// in r until the next operation completes.
// Optional build macro SEQ_MULT_EARLY_DONE_EN: finish as soon as no multiplier
// bits remain, instead of always taking W cycles.
module seq_mult_param #(
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            is_signed,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  r
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned PW = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            last;
    logic            early;

    logic            sign;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mag_a;
    logic [W-1:0]    mag_b;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    abs_a;
    logic [W-1:0]    abs_b;
    logic [PW-1:0]   acc_sum;
    logic [PW-1:0]   prod;

    // Operand magnitudes; the most negative value maps to 2^(W-1), which still fits
    always_comb begin
        abs_a = a;
        abs_b = b;
        if (is_signed && a[W-1]) abs_a = ~a + W'(1);
        if (is_signed && b[W-1]) abs_b = ~b + W'(1);
    end

    // One shift-add step and the sign-corrected product it would produce
    always_comb begin
        acc_sum = acc;
        if (mag_b[0]) acc_sum = acc + mag_a;
        prod = acc_sum;
        if (sign) prod = ~acc_sum + PW'(1);
    end

`ifdef SEQ_MULT_EARLY_DONE_EN
    // No multiplier bits left after this step: the remaining steps would add nothing
    assign early = ((mag_b >> 1) == '0);
`else
    assign early = 1'b0;
`endif

    // Next-state logic and load/finish strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CW'(1) || early) begin
                    state_nxt = DONE;
                    last      = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered status outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            sign  <= 1'b0;
            acc   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                sign  <= is_signed & (a[W-1] ^ b[W-1]);
                mag_a <= PW'(abs_a);
                mag_b <= abs_b;
                acc   <= '0;
                cnt   <= CW'(W);
            end else if (state == RUN) begin
                acc   <= acc_sum;
                mag_a <= mag_a << 1;
                mag_b <= mag_b >> 1;
                cnt   <= cnt - CW'(1);
            end
            if (last) r <= prod;
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: W=8 and W=16 instances on one clock.
// Expected latencies follow the SEQ_MULT_EARLY_DONE_EN build setting.
`timescale 1ns/1ps
module tb_seq_mult_param;

    logic        clk;
    logic        rst;

    logic        start8, s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;

    logic        start16, s16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] r16;

    logic        sel16;
    logic        dn, bs;
    logic [31:0] rr;

    int checks;
    int errors;

    seq_mult_param #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .is_signed(s8), .busy(busy8), .done(done8), .r(r8)
    );

    seq_mult_param #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .is_signed(s16), .busy(busy16), .done(done16), .r(r16)
    );

    assign dn = sel16 ? done16 : done8;
    assign bs = sel16 ? busy16 : busy8;
    assign rr = sel16 ? r16 : {16'h0, r8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-derived latency: early value with the macro, full width without
    function automatic int lat(input int early_v, input int full_v);
`ifdef SEQ_MULT_EARLY_DONE_EN
        return early_v;
`else
        return full_v;
`endif
    endfunction

    task automatic run_op(input bit w16, input logic [15:0] aa, input logic [15:0] bb,
                          input logic sg, input logic [31:0] exp_r, input int exp_lat,
                          input string tag);
        int n;
        int nb;
        @(negedge clk);
        sel16 = w16;
        if (w16) begin
            a16 = aa; b16 = bb; s16 = sg; start16 = 1'b1;
        end else begin
            a8 = aa[7:0]; b8 = bb[7:0]; s8 = sg; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        n = 0; nb = 0;
        while (!dn && n < 64) begin
            if (bs) nb++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, 64'(nb), 64'(exp_lat));
        check({tag, "_r"}, 64'(rr), 64'(exp_r));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(dn), 64'(0));
        check({tag, "_hold"}, 64'(rr), 64'(exp_r));
    endtask

    initial begin
        int n;
        int ndone;
        int first;
        checks = 0; errors = 0;
        rst = 1'b1; sel16 = 1'b0;
        start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy8", 64'(busy8), 64'(0));
        check("rst_done8", 64'(done8), 64'(0));
        check("rst_r8", 64'(r8), 64'(0));
        check("rst_r16", 64'(r16), 64'(0));

        // Basic products, W=8
        run_op(1'b0, 16'd200, 16'd150, 1'b0, 32'h7530, 8, "u200x150");
        run_op(1'b0, 16'hFD, 16'd5, 1'b1, 32'hFFF1, lat(3, 8), "sm3x5");
        run_op(1'b0, 16'h80, 16'h80, 1'b1, 32'h4000, 8, "s80x80");
        run_op(1'b0, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 8, "uFFxFF");
        run_op(1'b0, 16'hFF, 16'hFF, 1'b1, 32'h0001, lat(1, 8), "sFFxFF");

        // start pulses inside RUN are ignored
        @(negedge clk);
        sel16 = 1'b0; a8 = 8'd12; b8 = 8'd200; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'd99; b8 = 8'd99;
        ndone = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            start8 = (i == 3 || i == 5);
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        start8 = 1'b0;
        check("ign_ndone", 64'(ndone), 64'(1));
        check("ign_lat", 64'(first), 64'(8));
        check("ign_r", 64'(r8), 64'h0960);

        // start held through DONE: back-to-back operation
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd20; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd100; b8 = 8'd50;
        n = 0;
        while (!done8 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_lat1", 64'(n), 64'(lat(5, 8)));
        check("b2b_r1", 64'(r8), 64'h00C8);
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_busy", 64'(busy8), 64'(1));
        check("b2b_rkeep", 64'(r8), 64'h00C8);
        n = 0;
        while (!done8 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_lat2", 64'(n), 64'(lat(6, 8)));
        check("b2b_r2", 64'(r8), 64'h1388);
        @(posedge clk); #1;

        // Reset during the 4th RUN cycle
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd255; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", 64'(busy8), 64'(0));
        check("mrst_done", 64'(done8), 64'(0));
        check("mrst_r", 64'(r8), 64'(0));
        @(posedge clk); #1;
        check("mrst_idle", 64'(busy8 | done8), 64'(0));
        run_op(1'b0, 16'd7, 16'd9, 1'b0, 32'h003F, lat(4, 8), "rst7x9");

        // Short multipliers
        run_op(1'b0, 16'd77, 16'h03, 1'b0, 32'h00E7, lat(2, 8), "b3");
        run_op(1'b0, 16'd77, 16'h00, 1'b0, 32'h0000, lat(1, 8), "b0");

        // W=16 reruns
        run_op(1'b1, 16'd200, 16'd150, 1'b0, 32'h0000_7530, lat(8, 16), "w16_u200x150");
        run_op(1'b1, 16'hFFFD, 16'd5, 1'b1, 32'hFFFF_FFF1, lat(3, 16), "w16_sm3x5");
        run_op(1'b1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 16, "w16_s8000");
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 16, "w16_uFFFF");
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, lat(1, 16), "w16_sFFFF");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
